// File: rtl/disp_layer_mixer.sv
// Two-stage display layer compositor.
// Priority mux of keyed/blinking layers over a frame-synchronised background.
module disp_layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int R_W = 4,
  parameter int G_W = 4,
  parameter int B_W = 4,
  parameter int H_W = 10,
  parameter int V_W = 10,
  parameter logic [R_W+G_W+B_W-1:0] KEY_RGB = '1,
  parameter logic [R_W+G_W+B_W-1:0] BG_RGB_RST = '0,
  parameter int BLINK_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid_i,
  input  logic [H_W-1:0]              req_h_addr_i,
  input  logic [V_W-1:0]              req_v_addr_i,
  input  logic [NUM_LAYERS-1:0]       layer_valid_i,
  input  logic [NUM_LAYERS*(R_W+G_W+B_W)-1:0] layer_rgb_i,
  input  logic                        frame_start_i,
  input  logic                        cfg_bg_we_i,
  input  logic [R_W+G_W+B_W-1:0]      cfg_bg_rgb_i,
  input  logic                        cfg_mask_we_i,
  input  logic [NUM_LAYERS-1:0]       cfg_en_i,
  input  logic [NUM_LAYERS-1:0]       cfg_blink_i,
  output logic                        out_valid_o,
  output logic [H_W-1:0]              out_h_addr_o,
  output logic [V_W-1:0]              out_v_addr_o,
  output logic [R_W-1:0]              vga_r_o,
  output logic [G_W-1:0]              vga_g_o,
  output logic [B_W-1:0]              vga_b_o
);

  localparam int PIX_W = R_W + G_W + B_W;
  localparam int LW = NUM_LAYERS * PIX_W;

  logic [PIX_W-1:0]      bg_sh_q, bg_sh_d, bg_act_q, bg_act_d;
  logic [NUM_LAYERS-1:0] en_sh_q, en_sh_d, en_act_q, en_act_d;
  logic [NUM_LAYERS-1:0] bl_sh_q, bl_sh_d, bl_act_q, bl_act_d;
  logic [BLINK_W-1:0]    fcnt_q, fcnt_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [H_W-1:0]        s1_h_q, s1_h_d;
  logic [V_W-1:0]        s1_v_q, s1_v_d;
  logic [LW-1:0]         s1_rgb_q, s1_rgb_d;
  logic [NUM_LAYERS-1:0] s1_opq_q, s1_opq_d;

  logic                  out_valid_q, out_valid_d;
  logic [H_W-1:0]        out_h_q, out_h_d;
  logic [V_W-1:0]        out_v_q, out_v_d;
  logic [PIX_W-1:0]      out_rgb_q, out_rgb_d;

  // Shadow writes; frame start promotes shadows (with same-cycle bypass via _d)
  always_comb begin
    bg_sh_d  = bg_sh_q;
    en_sh_d  = en_sh_q;
    bl_sh_d  = bl_sh_q;
    bg_act_d = bg_act_q;
    en_act_d = en_act_q;
    bl_act_d = bl_act_q;
    fcnt_d   = fcnt_q;
    if (cfg_bg_we_i) bg_sh_d = cfg_bg_rgb_i;
    if (cfg_mask_we_i) begin
      en_sh_d = cfg_en_i;
      bl_sh_d = cfg_blink_i;
    end
    if (frame_start_i) begin
      bg_act_d = bg_sh_d;
      en_act_d = en_sh_d;
      bl_act_d = bl_sh_d;
      fcnt_d   = fcnt_q + BLINK_W'(1);
    end
  end

  // Stage 1: capture request and resolve per-layer opacity
  always_comb begin
    s1_valid_d = req_valid_i;
    s1_h_d     = req_h_addr_i;
    s1_v_d     = req_v_addr_i;
    s1_rgb_d   = layer_rgb_i;
    s1_opq_d   = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      s1_opq_d[k] = layer_valid_i[k] & en_act_q[k]
                  & (layer_rgb_i[k*PIX_W +: PIX_W] != KEY_RGB)
                  & ~(bl_act_q[k] & fcnt_q[BLINK_W-1]);
    end
  end

  // Stage 2: lowest-index opaque layer wins, else background; blank if idle
  always_comb begin
    logic [PIX_W-1:0] sel;
    sel = bg_act_q;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (s1_opq_q[k]) sel = s1_rgb_q[k*PIX_W +: PIX_W];
    end
    out_valid_d = s1_valid_q;
    out_h_d     = s1_h_q;
    out_v_d     = s1_v_q;
    out_rgb_d   = s1_valid_q ? sel : '0;
  end

  // All state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bg_sh_q     <= BG_RGB_RST;
      bg_act_q    <= BG_RGB_RST;
      en_sh_q     <= '1;
      en_act_q    <= '1;
      bl_sh_q     <= '0;
      bl_act_q    <= '0;
      fcnt_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      s1_rgb_q    <= '0;
      s1_opq_q    <= '0;
      out_valid_q <= 1'b0;
      out_h_q     <= '0;
      out_v_q     <= '0;
      out_rgb_q   <= '0;
    end else begin
      bg_sh_q     <= bg_sh_d;
      bg_act_q    <= bg_act_d;
      en_sh_q     <= en_sh_d;
      en_act_q    <= en_act_d;
      bl_sh_q     <= bl_sh_d;
      bl_act_q    <= bl_act_d;
      fcnt_q      <= fcnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_h_q      <= s1_h_d;
      s1_v_q      <= s1_v_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_opq_q    <= s1_opq_d;
      out_valid_q <= out_valid_d;
      out_h_q     <= out_h_d;
      out_v_q     <= out_v_d;
      out_rgb_q   <= out_rgb_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_h_addr_o = out_h_q;
  assign out_v_addr_o = out_v_q;
  assign vga_r_o      = out_rgb_q[PIX_W-1 -: R_W];
  assign vga_g_o      = out_rgb_q[G_W+B_W-1 -: G_W];
  assign vga_b_o      = out_rgb_q[B_W-1:0];

endmodule

// File: tb/tb_disp_layer_mixer.sv
// Bench for disp_layer_mixer: directed scenarios plus random stream
// checked against a cycle-level behavioural model.
module tb_disp_layer_mixer;

  localparam int NL = 4;
  localparam int PW = 12;
  localparam logic [PW-1:0] KEY = 12'hFFF;
  localparam logic [PW-1:0] BGR = 12'h000;

  logic          clk = 0;
  logic          rst = 1;
  logic          req_valid = 0;
  logic [9:0]    req_h = 0;
  logic [9:0]    req_v = 0;
  logic [NL-1:0] lay_v = 0;
  logic [NL*PW-1:0] lay_rgb = 0;
  logic          fs = 0;
  logic          bg_we = 0;
  logic [PW-1:0] bg_rgb = 0;
  logic          m_we = 0;
  logic [NL-1:0] en_in = 0;
  logic [NL-1:0] bl_in = 0;
  logic          o_valid;
  logic [9:0]    o_h, o_v;
  logic [3:0]    o_r, o_g, o_b;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [PW-1:0] m_bg_sh, m_bg_act;
  logic [NL-1:0] m_en_sh, m_en_act, m_bl_sh, m_bl_act;
  int            m_frames;
  logic          m_s1_valid, m_s1_hit;
  logic [9:0]    m_s1_h, m_s1_v;
  logic [PW-1:0] m_s1_col;

  disp_layer_mixer dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_h_addr_i(req_h), .req_v_addr_i(req_v),
    .layer_valid_i(lay_v), .layer_rgb_i(lay_rgb),
    .frame_start_i(fs),
    .cfg_bg_we_i(bg_we), .cfg_bg_rgb_i(bg_rgb),
    .cfg_mask_we_i(m_we), .cfg_en_i(en_in), .cfg_blink_i(bl_in),
    .out_valid_o(o_valid), .out_h_addr_o(o_h), .out_v_addr_o(o_v),
    .vga_r_o(o_r), .vga_g_o(o_g), .vga_b_o(o_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] obs_rgb();
    return {o_r, o_g, o_b};
  endfunction

  task automatic model_reset();
    m_bg_sh = BGR; m_bg_act = BGR;
    m_en_sh = '1; m_en_act = '1;
    m_bl_sh = '0; m_bl_act = '0;
    m_frames = 0;
    m_s1_valid = 0; m_s1_hit = 0;
    m_s1_h = 0; m_s1_v = 0; m_s1_col = 0;
  endtask

  task automatic idle_in();
    req_valid = 0; lay_v = 0; fs = 0; bg_we = 0; m_we = 0;
  endtask

  // one clock: predict, advance model, clock DUT, compare
  task automatic step();
    logic          e_v;
    logic [9:0]    e_h, e_vv;
    logic [PW-1:0] e_rgb, px;
    logic          hidden;
    e_v  = m_s1_valid;
    e_h  = m_s1_h;
    e_vv = m_s1_v;
    e_rgb = !m_s1_valid ? '0 : (m_s1_hit ? m_s1_col : m_bg_act);
    hidden = ((m_frames % 32) >= 16);
    m_s1_valid = req_valid;
    m_s1_h = req_h;
    m_s1_v = req_v;
    m_s1_hit = 0;
    m_s1_col = 0;
    for (int k = 0; k < NL; k++) begin
      px = lay_rgb[k*PW +: PW];
      if (!m_s1_hit && lay_v[k] && m_en_act[k] && px != KEY
          && !(m_bl_act[k] && hidden)) begin
        m_s1_hit = 1;
        m_s1_col = px;
      end
    end
    if (bg_we) m_bg_sh = bg_rgb;
    if (m_we) begin
      m_en_sh = en_in;
      m_bl_sh = bl_in;
    end
    if (fs) begin
      m_bg_act = m_bg_sh;
      m_en_act = m_en_sh;
      m_bl_act = m_bl_sh;
      m_frames++;
    end
    @(posedge clk);
    #1;
    chk("valid", {31'd0, o_valid}, {31'd0, e_v});
    chk("addr", {12'd0, o_h, o_v}, {12'd0, e_h, e_vv});
    chk("rgb", {20'd0, obs_rgb()}, {20'd0, e_rgb});
  endtask

  task automatic req(input int h, input int v, input logic [NL-1:0] lv,
                     input logic [NL*PW-1:0] rgb);
    req_valid = 1;
    req_h = 10'(h);
    req_v = 10'(v);
    lay_v = lv;
    lay_rgb = rgb;
  endtask

  task automatic pulse_rst();
    rst = 1;
    #2;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_addr", {12'd0, o_h, o_v}, 32'd0);
    chk("rst_rgb", {20'd0, obs_rgb()}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int fcnt;
    logic [PW-1:0] want;
    model_reset();
    #1;
    chk("por_valid", {31'd0, o_valid}, 32'd0);
    chk("por_rgb", {20'd0, obs_rgb()}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // background only at (5,7)
    req(5, 7, 4'b0000, '0);
    step();
    idle_in();
    step();
    chk("bg_valid", {31'd0, o_valid}, 32'd1);
    chk("bg_addr", {12'd0, o_h, o_v}, {12'd0, 10'd5, 10'd7});
    chk("bg_rgb", {20'd0, obs_rgb()}, {20'd0, BGR});

    // keyed layer 0 skipped, layer 1 wins over 3
    req(1, 2, 4'b1011, {12'h00F, 12'h000, 12'h0F0, KEY});
    step();
    idle_in();
    step();
    chk("key_skip", {20'd0, obs_rgb()}, 32'h0F0);

    // mask write mid-frame stays in shadow until frame start
    m_we = 1; en_in = 4'b1101; bl_in = 4'b0000;
    step();
    m_we = 0;
    req(1, 2, 4'b1011, {12'h00F, 12'h000, 12'h0F0, KEY});
    step();
    idle_in();
    step();
    chk("shadow_hold", {20'd0, obs_rgb()}, 32'h0F0);
    fs = 1;
    step();
    fs = 0;
    req(1, 2, 4'b1011, {12'h00F, 12'h000, 12'h0F0, KEY});
    step();
    idle_in();
    step();
    chk("mask_commit", {20'd0, obs_rgb()}, 32'h00F);

    // bg write coincident with frame start commits directly
    bg_we = 1; bg_rgb = 12'h123; fs = 1;
    step();
    idle_in();
    req(3, 4, 4'b0000, '0);
    step();
    idle_in();
    step();
    chk("bg_bypass", {20'd0, obs_rgb()}, 32'h123);

    // blink on layer 0, set with frame start (bypass)
    m_we = 1; en_in = 4'b1111; bl_in = 4'b0001; fs = 1;
    step();
    idle_in();
    fcnt = 3;
    for (int i = 0; i < 40; i++) begin
      want = ((fcnt % 32) < 16) ? 12'hF00 : 12'h123;
      req(i, 9, 4'b0001, {36'd0, 12'hF00});
      step();
      idle_in();
      step();
      chk("blink", {20'd0, obs_rgb()}, {20'd0, want});
      fs = 1;
      step();
      fs = 0;
      fcnt++;
    end

    // continuous random stream with a mid-stream reset
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_h = 10'($urandom);
      req_v = 10'($urandom);
      lay_v = NL'($urandom);
      for (int k = 0; k < NL; k++)
        lay_rgb[k*PW +: PW] = ($urandom_range(0, 3) == 0) ? KEY
                                                          : PW'($urandom);
      fs = ($urandom_range(0, 7) == 0);
      bg_we = ($urandom_range(0, 5) == 0);
      bg_rgb = PW'($urandom);
      m_we = ($urandom_range(0, 5) == 0);
      en_in = NL'($urandom);
      bl_in = NL'($urandom);
      if (i == 300) pulse_rst();
      step();
    end
    idle_in();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
